// File: rtl/cpu_cnt_pkg.sv
// cpu_cnt_pkg: shared definitions for the CPU up/down modulo counters.
//   - cnt_op_e   : decoded per-edge operation (hold, clear, load, up, down)
//   - cnt_clog2  : ceil(log2) helper for sizing counters from a modulus
//   - default widths of the counter instances used in the CPU
package cpu_cnt_pkg;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_CLR,
      OP_LD,
      OP_UP,
      OP_DN
   } cnt_op_e;

   localparam int SEQ_CNT_W      = 5;  // hardwired control sequencer
   localparam int PC_CNT_W       = 6;  // program counter
   localparam int ACC_CNT_W      = 9;  // accumulator
   localparam int DEFAULT_STEP_W = 3;

   // Bits needed to hold values 0..v-1 (minimum 1).
   function automatic int cnt_clog2(input longint unsigned v);
      int r;
      r = 0;
      for (int i = 0; i < 64; i++) begin
         if ((64'd1 << i) < v) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/counter_mod_next.sv
// counter_mod_next: combinational next-count and wrap detect.
//   state : current count
//   step  : step magnitude (0 = no change)
//   up    : 1 = count up, 0 = count down
//   nxt   : resulting count
//   wrap  : the step crossed MAX_VAL (up) or 0 (down)
// Build option COUNTER_MOD_SAT_EN: clamp at MAX_VAL/0 instead of wrapping.
// All sums are WIDTH+1 bits, so MAX_VAL = 2**WIDTH-1 cannot overflow.
module counter_mod_next
   import cpu_cnt_pkg::*;
#(
   parameter int               WIDTH   = 6,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
   parameter int               STEP_W  = DEFAULT_STEP_W
) (
   input  logic [WIDTH-1:0]  state,
   input  logic [STEP_W-1:0] step,
   input  logic              up,
   output logic [WIDTH-1:0]  nxt,
   output logic              wrap
);

   localparam logic [WIDTH:0] LIM = {1'b0, MAX_VAL};
   localparam logic [WIDTH:0] MOD = LIM + (WIDTH+1)'(1);

   logic [WIDTH:0] cur, stp, sum;

   assign cur = {1'b0, state};
   assign stp = (WIDTH+1)'(step);
   assign sum = cur + stp;

   always_comb begin
      nxt  = state;
      wrap = 1'b0;
      if (up) begin
         if (sum > LIM) begin
            wrap = 1'b1;
`ifdef COUNTER_MOD_SAT_EN
            nxt  = MAX_VAL;
`else
            nxt  = WIDTH'(sum - MOD);
`endif
         end else begin
            nxt = sum[WIDTH-1:0];
         end
      end else begin
         if (stp > cur) begin
            wrap = 1'b1;
`ifdef COUNTER_MOD_SAT_EN
            nxt  = '0;
`else
            // state + MOD - step, arranged so the intermediate stays below MOD
            nxt  = WIDTH'(MOD - (stp - cur));
`endif
         end else begin
            nxt = WIDTH'(cur - stp);
         end
      end
   end

endmodule

// File: rtl/counter_mod_updown.sv
// counter_mod_updown: up/down modulo counter with load, clear, step,
// sticky overflow/underflow flags and a one-cycle wrap pulse.
// All state changes on the falling edge of CLK; RST is async active-high.
//   CLK, RST         : clock (negedge active), async reset
//   CLR, LD          : sync clear to RST_VAL, sync load of DATA (clamped)
//   INC, DEC, STEP   : count up/down by STEP; both or neither = hold
//   DATA             : load value
//   FLAG_CLR         : clears OVF/UNF (a same-edge wrap still sets them)
//   STATE            : registered count
//   OVF, UNF         : sticky up-wrap / down-wrap flags
//   WRAP             : registered pulse for the cycle after a wrap event
// Build option COUNTER_MOD_SAT_EN: saturate instead of wrap (same ports).
module counter_mod_updown
   import cpu_cnt_pkg::*;
#(
   parameter int               WIDTH   = 6,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
   parameter int               STEP_W  = DEFAULT_STEP_W,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CLR,
   input  logic              LD,
   input  logic              INC,
   input  logic              DEC,
   input  logic [STEP_W-1:0] STEP,
   input  logic [WIDTH-1:0]  DATA,
   input  logic              FLAG_CLR,
   output logic [WIDTH-1:0]  STATE,
   output logic              OVF,
   output logic              UNF,
   output logic              WRAP
);

   cnt_op_e          op;
   logic [WIDTH-1:0] cnt_nxt, state_d;
   logic             cnt_wrap, ovf_d, unf_d, wrap_d;
   logic [WIDTH:0]   step_ext;

   // priority: CLR > LD > exactly one of INC/DEC
   always_comb begin
      op = OP_HOLD;
      if (CLR)             op = OP_CLR;
      else if (LD)         op = OP_LD;
      else if (INC && !DEC) op = OP_UP;
      else if (DEC && !INC) op = OP_DN;
   end

   counter_mod_next #(
      .WIDTH   (WIDTH),
      .MAX_VAL (MAX_VAL),
      .STEP_W  (STEP_W)
   ) u_next (
      .state (STATE),
      .step  (STEP),
      .up    (op == OP_UP),
      .nxt   (cnt_nxt),
      .wrap  (cnt_wrap)
   );

   always_comb begin
      state_d = STATE;
      wrap_d  = 1'b0;
      ovf_d   = OVF & ~FLAG_CLR;
      unf_d   = UNF & ~FLAG_CLR;
      case (op)
         OP_CLR: state_d = RST_VAL;
         OP_LD:  state_d = (DATA > MAX_VAL) ? MAX_VAL : DATA;
         OP_UP: begin
            state_d = cnt_nxt;
            wrap_d  = cnt_wrap;
            if (cnt_wrap) ovf_d = 1'b1;
         end
         OP_DN: begin
            state_d = cnt_nxt;
            wrap_d  = cnt_wrap;
            if (cnt_wrap) unf_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         STATE <= RST_VAL;
         OVF   <= 1'b0;
         UNF   <= 1'b0;
         WRAP  <= 1'b0;
      end else begin
         STATE <= state_d;
         OVF   <= ovf_d;
         UNF   <= unf_d;
         WRAP  <= wrap_d;
      end
   end

   // a step larger than the modulus has no defined meaning
   assign step_ext = (WIDTH+1)'(STEP);

   a_step_legal: assert property (@(negedge CLK) disable iff (RST)
      (INC || DEC) |-> (step_ext <= {1'b0, MAX_VAL}));

endmodule
